// File: rtl/fc_stream_layer_pkg.sv
// Shared types and width helpers for the streaming fully connected layer.
// The layer walks its neurons through the states IDLE, STREAM, DRAIN, EMIT and DONE.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        DRAIN  = 3'd2,
        EMIT   = 3'd3,
        DONE   = 3'd4
    } fc_state_t;

    // Address/counter width that stays at least one bit for tiny configurations.
    function automatic int fc_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fc_stream_layer_if.sv
// Weight RAM, bias RAM and result-stream bus of fc_stream_layer.
// The master side is the layer; the slave side is the RAMs plus the downstream consumer.
interface fc_stream_layer_if import fc_pkg::*; #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int LANES    = 4,
    parameter int OUT_SIZE = 512,
    parameter int BEATS    = 196
) ();

    localparam int WA_W = fc_width(OUT_SIZE * BEATS);
    localparam int N_W  = fc_width(OUT_SIZE);

    logic                     w_rd_en;
    logic [WA_W-1:0]          w_rd_addr;
    logic [LANES*DATA_W-1:0]  w_rd_data;
    logic                     b_rd_en;
    logic [N_W-1:0]           b_rd_addr;
    logic [ACC_W-1:0]         b_rd_data;
    logic                     out_valid;
    logic [N_W-1:0]           out_idx;
    logic [ACC_W-1:0]         out_data;

    modport master (
        output w_rd_en, w_rd_addr, b_rd_en, b_rd_addr, out_valid, out_idx, out_data,
        input  w_rd_data, b_rd_data
    );

    modport slave (
        input  w_rd_en, w_rd_addr, b_rd_en, b_rd_addr, out_valid, out_idx, out_data,
        output w_rd_data, b_rd_data
    );

endinterface

// File: rtl/fc_stream_layer_dot_lanes.sv
// Combinational LANES-wide signed multiply-and-sum, result sign-extended to ACC_W.
// Products are full 2*DATA_W precision; the sum wraps modulo 2^ACC_W.
module fc_dot_lanes #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int LANES  = 4
) (
    input  logic [LANES*DATA_W-1:0] x,
    input  logic [LANES*DATA_W-1:0] w,
    output logic [ACC_W-1:0]        sum
);

    function automatic logic [ACC_W-1:0] sext_prod(input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] p;
        p = a * b;
        return {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
    endfunction

    // Sum of the lane products for one weight beat.
    always_comb begin
        sum = {ACC_W{1'b0}};
        for (int j = 0; j < LANES; j++) begin
            sum = sum + sext_prod(x[j*DATA_W +: DATA_W], w[j*DATA_W +: DATA_W]);
        end
    end

endmodule

// File: rtl/fc_stream_layer.sv
// Streaming fully connected layer: y[n] = b[n] + sum_i W[n][i]*x[i], one result beat per neuron.
// Optional macro FC_RELU_EN fuses a ReLU into the emitted result.
module fc_stream_layer import fc_pkg::*; #(
    parameter int IN_SIZE  = 784,
    parameter int OUT_SIZE = 512,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int LANES    = 4,
    parameter int RD_LAT   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    input  logic [IN_SIZE*DATA_W-1:0] inputs,
    fc_stream_layer_if.master         bus
);

    localparam int BEATS     = IN_SIZE / LANES;
    localparam int WA_W      = fc_width(OUT_SIZE * BEATS);
    localparam int N_W       = fc_width(OUT_SIZE);
    localparam int K_W       = fc_width(BEATS);
    localparam int LANE_BITS = LANES * DATA_W;
    // All valid-pipe stages except the last; empty means the final beat is being consumed now.
    localparam logic [RD_LAT-1:0] LOW_MASK = {RD_LAT{1'b1}} >> 1'b1;

    fc_state_t             state_r, state_s;
    logic [N_W-1:0]        n_r, n_s;
    logic [K_W-1:0]        k_r, rk_r;
    logic [RD_LAT-1:0]     w_pipe_r, b_pipe_r;
    logic [ACC_W-1:0]      acc_r, acc_next_s, dot_s, out_data_s, out_data_r;
    logic [LANE_BITS-1:0]  x_beat_s;
    logic                  enter_s, w_valid_s, b_valid_s;
    logic                  busy_r, done_r, w_rd_en_r, b_rd_en_r, out_valid_r;
    logic [WA_W-1:0]       w_rd_addr_r;
    logic [N_W-1:0]        b_rd_addr_r, out_idx_r;

    assign w_valid_s = w_pipe_r[RD_LAT-1];
    assign b_valid_s = b_pipe_r[RD_LAT-1];
    assign x_beat_s  = inputs[int'(rk_r) * LANE_BITS +: LANE_BITS];

    fc_dot_lanes #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LANES(LANES)) u_dot (
        .x   (x_beat_s),
        .w   (bus.w_rd_data),
        .sum (dot_s)
    );

    // Next-state decode of the layer sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (start) state_s = STREAM; else state_s = IDLE;
            STREAM:  if (k_r == K_W'(BEATS - 1)) state_s = DRAIN; else state_s = STREAM;
            DRAIN:   if ((w_pipe_r & LOW_MASK) == {RD_LAT{1'b0}}) state_s = EMIT;
                     else state_s = DRAIN;
            EMIT:    if (n_r == N_W'(OUT_SIZE - 1)) state_s = DONE; else state_s = STREAM;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Neuron index, accumulator update and optional ReLU of the value being emitted.
    always_comb begin
        enter_s = (state_s == STREAM) && (state_r != STREAM);
        if (state_r == IDLE) begin
            n_s = {N_W{1'b0}};
        end else if ((state_r == EMIT) && (state_s == STREAM)) begin
            n_s = n_r + N_W'(1'b1);
        end else begin
            n_s = n_r;
        end
        acc_next_s = acc_r + (w_valid_s ? dot_s : {ACC_W{1'b0}})
                           + (b_valid_s ? bus.b_rd_data : {ACC_W{1'b0}});
`ifdef FC_RELU_EN
        out_data_s = acc_next_s[ACC_W-1] ? {ACC_W{1'b0}} : acc_next_s;
`else
        out_data_s = acc_next_s;
`endif
    end

    // Sequencer state, counters, read-valid pipes, accumulator and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            n_r         <= {N_W{1'b0}};
            k_r         <= {K_W{1'b0}};
            rk_r        <= {K_W{1'b0}};
            w_pipe_r    <= {RD_LAT{1'b0}};
            b_pipe_r    <= {RD_LAT{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            w_rd_en_r   <= 1'b0;
            b_rd_en_r   <= 1'b0;
            w_rd_addr_r <= {WA_W{1'b0}};
            b_rd_addr_r <= {N_W{1'b0}};
            out_valid_r <= 1'b0;
            out_idx_r   <= {N_W{1'b0}};
            out_data_r  <= {ACC_W{1'b0}};
        end else begin
            state_r   <= state_s;
            n_r       <= n_s;
            k_r       <= ((state_s == STREAM) && !enter_s) ? k_r + K_W'(1'b1) : {K_W{1'b0}};
            w_pipe_r  <= (w_pipe_r << 1'b1) | RD_LAT'(w_rd_en_r);
            b_pipe_r  <= (b_pipe_r << 1'b1) | RD_LAT'(b_rd_en_r);
            busy_r    <= (state_s == STREAM) || (state_s == DRAIN) || (state_s == EMIT);
            done_r    <= (state_s == DONE);
            w_rd_en_r <= (state_s == STREAM);
            b_rd_en_r <= enter_s;
            acc_r     <= enter_s ? {ACC_W{1'b0}} : acc_next_s;
            // Beat addresses n*BEATS+k are contiguous over the whole layer.
            if (state_r == IDLE) begin
                w_rd_addr_r <= {WA_W{1'b0}};
            end else if (w_rd_en_r) begin
                w_rd_addr_r <= w_rd_addr_r + WA_W'(1'b1);
            end
            if (enter_s) begin
                b_rd_addr_r <= n_s;
            end
            if (w_valid_s) begin
                rk_r <= (rk_r == K_W'(BEATS - 1)) ? {K_W{1'b0}} : rk_r + K_W'(1'b1);
            end
            out_valid_r <= (state_s == EMIT);
            if (state_s == EMIT) begin
                out_idx_r  <= n_r;
                out_data_r <= out_data_s;
            end
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign bus.w_rd_en   = w_rd_en_r;
    assign bus.w_rd_addr = w_rd_addr_r;
    assign bus.b_rd_en   = b_rd_en_r;
    assign bus.b_rd_addr = b_rd_addr_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.out_data  = out_data_r;

endmodule

// File: tb/tb_fc_stream_layer.sv
// Self-checking bench for fc_stream_layer: table of layer vectors, random layer, abort and restart.
// Expected results go into a scoreboard queue at launch and are popped on each out_valid.
module tb_fc_stream_layer;

    localparam int IN_SIZE   = 8;
    localparam int OUT_SIZE  = 3;
    localparam int DATA_W    = 8;
    localparam int ACC_W     = 32;
    localparam int LANES     = 2;
    localparam int RD_LAT    = 2;
    localparam int BEATS     = IN_SIZE / LANES;
    localparam int LAYER_CYC = OUT_SIZE * (BEATS + RD_LAT + 1) + 1;
`ifdef FC_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic                      busy;
    logic                      done;
    logic [IN_SIZE*DATA_W-1:0] inputs;

    fc_stream_layer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LANES(LANES),
                         .OUT_SIZE(OUT_SIZE), .BEATS(BEATS)) bus ();

    fc_stream_layer #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .DATA_W(DATA_W),
                      .ACC_W(ACC_W), .LANES(LANES), .RD_LAT(RD_LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .inputs (inputs),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int data;
    } exp_t;

    typedef struct packed {
        logic [7:0] xv;
        logic [7:0] wv;
        int b0, b1, b2;
        int r0, r1, r2;
        int u0, u1, u2;
    } vec_t;

    localparam int NV = 5;
    vec_t tv [NV];

    logic signed [DATA_W-1:0] wmem [OUT_SIZE][IN_SIZE];
    logic signed [DATA_W-1:0] xmem [IN_SIZE];
    logic signed [ACC_W-1:0]  bmem [OUT_SIZE];
    logic [LANES*DATA_W-1:0]  w_s1;
    logic [ACC_W-1:0]         b_s1;

    exp_t sbq [$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_valid = 0;
    int   n_done = 0;
    int   exp_addr = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [LANES*DATA_W-1:0] w_beat(input int a);
        logic [LANES*DATA_W-1:0] r;
        r = '0;
        if (a / BEATS < OUT_SIZE) begin
            for (int j = 0; j < LANES; j++)
                r[j*DATA_W +: DATA_W] = wmem[a / BEATS][(a % BEATS) * LANES + j];
        end
        return r;
    endfunction

    // Two-cycle RAM models; a non-zero filler shows up if unstrobed data is ever accumulated.
    always_ff @(posedge clk) begin
        w_s1          <= bus.w_rd_en ? w_beat(int'(bus.w_rd_addr)) : {LANES{8'h11}};
        bus.w_rd_data <= w_s1;
        b_s1          <= bus.b_rd_en ? bmem[bus.b_rd_addr] : 32'd77;
        bus.b_rd_data <= b_s1;
    end

    // Output scoreboard and read-strobe sequence checks.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid) begin
                n_valid++;
                if (sbq.size() == 0) begin
                    chk("unexpected_out_valid_idx", longint'(bus.out_idx), -1);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("out_idx", longint'(bus.out_idx), mon_e.idx);
                    chk("out_data", longint'($signed(bus.out_data)), mon_e.data);
                end
            end
            if (done) n_done++;
            if (bus.w_rd_en) begin
                chk("w_rd_addr", longint'(bus.w_rd_addr), exp_addr);
                chk("b_rd_en_on_beat", longint'(bus.b_rd_en), (exp_addr % BEATS) == 0);
                if (bus.b_rd_en) chk("b_rd_addr", longint'(bus.b_rd_addr), exp_addr / BEATS);
                exp_addr++;
            end else begin
                chk("b_rd_en_without_w", longint'(bus.b_rd_en), 0);
            end
        end
    end

    task automatic load_uniform(input logic [7:0] xv, input logic [7:0] wv,
                                input int b0, input int b1, input int b2);
        for (int i = 0; i < IN_SIZE; i++) begin
            inputs[i*DATA_W +: DATA_W] = xv;
            for (int n = 0; n < OUT_SIZE; n++) wmem[n][i] = wv;
        end
        bmem[0] = b0;
        bmem[1] = b1;
        bmem[2] = b2;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_w_rd_en"}, longint'(bus.w_rd_en), 0);
        chk({tag, "_b_rd_en"}, longint'(bus.b_rd_en), 0);
        chk({tag, "_out_valid"}, longint'(bus.out_valid), 0);
        chk({tag, "_w_rd_addr"}, longint'(bus.w_rd_addr), 0);
        chk({tag, "_b_rd_addr"}, longint'(bus.b_rd_addr), 0);
        chk({tag, "_out_idx"}, longint'(bus.out_idx), 0);
        chk({tag, "_out_data"}, longint'(bus.out_data), 0);
    endtask

    task automatic run_layer(input bit stray);
        int cyc;
        int v0;
        int d0;
        v0 = n_valid;
        d0 = n_done;
        exp_addr = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        chk("busy_after_start", longint'(busy), 1);
        while (!done && cyc < 200) begin
            start = stray && (cyc >= 4) && (cyc < 6);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("start_to_done_cycles", cyc, LAYER_CYC);
        chk("busy_in_done", longint'(busy), 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_done_ignored", longint'(busy), 0);
        @(posedge clk); #1;
        chk("out_valid_count", n_valid - v0, OUT_SIZE);
        chk("done_pulse_count", n_done - d0, 1);
        chk("scoreboard_empty", sbq.size(), 0);
    endtask

    function automatic int relu(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    initial begin
        tv[0] = '{8'h01, 8'h01, 0, 10, -5, 8, 18, 3, 8, 18, 3};
        tv[1] = '{8'h80, 8'h80, 0, 0, 0, 131072, 131072, 131072, 131072, 131072, 131072};
        tv[2] = '{8'h00, 8'h00, -100, 7, -1, -100, 7, -1, 0, 7, 0};
        tv[3] = '{8'h03, 8'hFE, 5, 0, 100, -43, -48, 52, 0, 0, 52};
        tv[4] = '{8'h7F, 8'h80, -1, 1, 130047, -130049, -130047, -1, 0, 0, 0};

        rst = 1'b1;
        start = 1'b0;
        inputs = '0;
        load_uniform(8'h00, 8'h00, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < NV; t++) begin
            load_uniform(tv[t].xv, tv[t].wv, tv[t].b0, tv[t].b1, tv[t].b2);
            sbq.push_back('{0, RELU ? tv[t].u0 : tv[t].r0});
            sbq.push_back('{1, RELU ? tv[t].u1 : tv[t].r1});
            sbq.push_back('{2, RELU ? tv[t].u2 : tv[t].r2});
            run_layer(t == 0);
        end

        // Random activations, weights and biases against a plain dot-product model.
        for (int i = 0; i < IN_SIZE; i++) begin
            xmem[i] = DATA_W'($urandom_range(0, 255));
            inputs[i*DATA_W +: DATA_W] = xmem[i];
            for (int n = 0; n < OUT_SIZE; n++) wmem[n][i] = DATA_W'($urandom_range(0, 255));
        end
        for (int n = 0; n < OUT_SIZE; n++) begin
            int s;
            bmem[n] = $signed($urandom_range(0, 4000)) - 2000;
            s = bmem[n];
            for (int i = 0; i < IN_SIZE; i++) s += int'(wmem[n][i]) * int'(xmem[i]);
            sbq.push_back('{n, RELU ? relu(s) : s});
        end
        run_layer(1'b0);

        // Abort in the drain of neuron 1, then a fresh layer must come out clean.
        load_uniform(8'h01, 8'h01, 0, 10, -5);
        for (int n = 0; n < OUT_SIZE; n++) sbq.push_back('{n, RELU ? tv[0].u0 : tv[0].r0});
        sbq[1].data = 18;
        sbq[2].data = 3;
        exp_addr = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("drain_no_w_strobe", longint'(bus.w_rd_en), 0);
        chk("drain_busy", longint'(busy), 1);
        rst = 1'b1;
        #1;
        check_zero("abort");
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        load_uniform(tv[3].xv, tv[3].wv, tv[3].b0, tv[3].b1, tv[3].b2);
        sbq.push_back('{0, RELU ? tv[3].u0 : tv[3].r0});
        sbq.push_back('{1, RELU ? tv[3].u1 : tv[3].r1});
        sbq.push_back('{2, RELU ? tv[3].u2 : tv[3].r2});
        run_layer(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
